// File: rtl/up_down_counter255_host_pkg.sv
// Shared types and constants for the up/down counter host sequencer.
package up_down_counter255_host_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CHECK,
        ST_WR_SETUP,
        ST_WR_STROBE,
        ST_WR_HOLD,
        ST_RD_SETUP,
        ST_RD_STROBE,
        ST_RD_CAPTURE,
        ST_START,
        ST_WAIT_EC,
        ST_FINISH
    } state_t;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_STROBE,
        PH_LAST
    } bus_phase_t;

    localparam logic [2:0] STS_OK          = 3'd0;
    localparam logic [2:0] STS_PARAM_ERR   = 3'd2;
    localparam logic [2:0] STS_VERIFY_FAIL = 3'd3;
    localparam logic [2:0] STS_RUN_ERR     = 3'd4;
    localparam logic [2:0] STS_TIMEOUT     = 3'd5;

    localparam logic [1:0] ADDR_PLR = 2'd0;
    localparam logic [1:0] ADDR_ULR = 2'd1;
    localparam logic [1:0] ADDR_LLR = 2'd2;
    localparam logic [1:0] ADDR_CCR = 2'd3;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Limits must bracket the preload: llr <= plr <= ulr.
    function automatic logic params_bad(input logic [7:0] plr,
                                        input logic [7:0] ulr,
                                        input logic [7:0] llr);
        return (llr > plr) || (plr > ulr);
    endfunction

endpackage

// File: rtl/up_down_counter255_host_bus_cycle_engine.sv
// Single 3-cycle bus transaction engine (setup / strobe / hold-or-capture).
module bus_cycle_engine (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic       req,
    input  logic       wr,
    input  logic [1:0] addr,
    input  logic [7:0] wdata,
    output logic       ack,
    output logic [7:0] rdata,
    output logic       nwr_out,
    output logic       nrd_out,
    output logic [1:0] addr_out,
    output logic [7:0] dout,
    output logic       dout_oe,
    input  logic [7:0] din
);
    import up_down_counter255_host_pkg::*;

    bus_phase_t phase_q;
    logic       wr_q;
    logic [1:0] addr_q;
    logic [7:0] wdata_q;
    logic       take;

    // A new request may start straight out of the last phase so cycles run back to back.
    assign take = req && ((phase_q == PH_IDLE) || (phase_q == PH_LAST));

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            phase_q <= PH_IDLE;
            wr_q    <= 1'b0;
            addr_q  <= 2'd0;
            wdata_q <= 8'd0;
        end else begin
            case (phase_q)
                PH_SETUP:  phase_q <= PH_STROBE;
                PH_STROBE: phase_q <= PH_LAST;
                default:   phase_q <= take ? PH_SETUP : PH_IDLE;
            endcase
            if (take) begin
                wr_q   <= wr;
                addr_q <= addr;
                if (wr) wdata_q <= wdata;
            end
        end
    end

    assign ack      = (phase_q == PH_LAST);
    assign rdata    = din;
    assign addr_out = addr_q;
    assign dout     = wdata_q;
    assign dout_oe  = wr_q && (phase_q != PH_IDLE);
    assign nwr_out  = !(wr_q && (phase_q == PH_STROBE));
    assign nrd_out  = !(!wr_q && ((phase_q == PH_STROBE) || (phase_q == PH_LAST)));

endmodule

// File: rtl/up_down_counter255_host.sv
// Host sequencer: program, verify and start the 8-bit up/down counter, then wait for end-of-cycle.
//   state       | meaning
//   IDLE        | ready for a command, bus released
//   CHECK       | validate latched limits
//   WR_*        | write PLR, ULR, LLR, CCR in turn
//   RD_*        | read back and compare the four registers
//   START       | one-cycle start pulse
//   WAIT_EC     | wait for ec / err / timeout
//   FINISH      | done pulse, bus released
module up_down_counter255_host #(
    parameter logic [15:0] TIMEOUT_CYC = 16'd4096,
    parameter int          VERIFY_EN   = 1
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] plr_in,
    input  logic [7:0] ulr_in,
    input  logic [7:0] llr_in,
    input  logic [7:0] ccr_in,
    output logic       ncs_out,
    output logic       nwr_out,
    output logic       nrd_out,
    output logic [1:0] addr_out,
    output logic [7:0] dout,
    output logic       dout_oe,
    input  logic [7:0] din,
    output logic       start_out,
    input  logic       err_in,
    input  logic       ec_in,
    input  logic [7:0] count_in,
    output logic       done,
    output logic [2:0] status,
    output logic [7:0] last_count
);
    import up_down_counter255_host_pkg::*;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  regs_q [4];
    logic [2:0]  status_q, status_d;
    logic [7:0]  last_count_q, last_count_d;
    logic [15:0] tmo_q, tmo_d;
    logic        latch;
    logic        eng_req, eng_wr, eng_ack;
    logic [7:0]  eng_rdata;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q      <= ST_IDLE;
            idx_q        <= 2'd0;
            status_q     <= STS_OK;
            last_count_q <= 8'd0;
            tmo_q        <= 16'd0;
            for (int i = 0; i < 4; i++) regs_q[i] <= 8'd0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            status_q     <= status_d;
            last_count_q <= last_count_d;
            tmo_q        <= tmo_d;
            if (latch) begin
                regs_q[ADDR_PLR] <= plr_in;
                regs_q[ADDR_ULR] <= ulr_in;
                regs_q[ADDR_LLR] <= llr_in;
                regs_q[ADDR_CCR] <= ccr_in;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        status_d     = status_q;
        last_count_d = last_count_q;
        tmo_d        = tmo_q;
        latch        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    latch    = 1'b1;
                    status_d = STS_OK;
                    state_d  = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (params_bad(regs_q[ADDR_PLR], regs_q[ADDR_ULR], regs_q[ADDR_LLR])) begin
                    status_d = STS_PARAM_ERR;
                    state_d  = ST_FINISH;
                end else begin
                    idx_d   = ADDR_PLR;
                    state_d = ST_WR_SETUP;
                end
            end
            ST_WR_SETUP:  state_d = ST_WR_STROBE;
            ST_WR_STROBE: state_d = ST_WR_HOLD;
            ST_WR_HOLD: begin
                if (eng_ack) begin
                    if (idx_q != ADDR_CCR) begin
                        idx_d   = idx_q + 2'd1;
                        state_d = ST_WR_SETUP;
                    end else if (VERIFY_EN != 0) begin
                        idx_d   = ADDR_PLR;
                        state_d = ST_RD_SETUP;
                    end else begin
                        state_d = ST_START;
                    end
                end
            end
            ST_RD_SETUP:  state_d = ST_RD_STROBE;
            ST_RD_STROBE: state_d = ST_RD_CAPTURE;
            ST_RD_CAPTURE: begin
                if (eng_ack) begin
                    if (eng_rdata != regs_q[idx_q]) begin
                        status_d = STS_VERIFY_FAIL;
                        state_d  = ST_FINISH;
                    end else if (idx_q == ADDR_CCR) begin
                        state_d = ST_START;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = ST_RD_SETUP;
                    end
                end
            end
            ST_START: begin
                tmo_d   = 16'd0;
                state_d = ST_WAIT_EC;
            end
            ST_WAIT_EC: begin
                // tmo_d counts WAIT_EC cycles elapsed including this one.
                tmo_d = sat_inc16(tmo_q);
                if (ec_in) begin
                    last_count_d = count_in;
                    status_d     = STS_OK;
                    state_d      = ST_FINISH;
                end else if (err_in) begin
                    status_d = STS_RUN_ERR;
                    state_d  = ST_FINISH;
                end else if (tmo_d == TIMEOUT_CYC) begin
                    status_d = STS_TIMEOUT;
                    state_d  = ST_FINISH;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Request is issued one cycle ahead so the engine's SETUP lines up with *_SETUP.
    assign eng_req = (state_d == ST_WR_SETUP) || (state_d == ST_RD_SETUP);
    assign eng_wr  = (state_d == ST_WR_SETUP);

    bus_cycle_engine u_bus (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .req      (eng_req),
        .wr       (eng_wr),
        .addr     (idx_d),
        .wdata    (regs_q[idx_d]),
        .ack      (eng_ack),
        .rdata    (eng_rdata),
        .nwr_out  (nwr_out),
        .nrd_out  (nrd_out),
        .addr_out (addr_out),
        .dout     (dout),
        .dout_oe  (dout_oe),
        .din      (din)
    );

    assign cmd_ready  = (state_q == ST_IDLE) && !reset_in;
    assign ncs_out    = !((state_q != ST_IDLE) && (state_q != ST_CHECK) && (state_q != ST_FINISH));
    assign start_out  = (state_q == ST_START);
    assign done       = (state_q == ST_FINISH);
    assign status     = status_q;
    assign last_count = last_count_q;

endmodule

// File: tb/tb_up_down_counter255_host.sv
// Directed bench for up_down_counter255_host with a register-file bus slave.
module tb_up_down_counter255_host;

    logic       clk_in = 1'b0;
    logic       reset_in = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] plr_in = 8'd0, ulr_in = 8'd0, llr_in = 8'd0, ccr_in = 8'd0;
    logic       ncs_out, nwr_out, nrd_out, dout_oe, start_out, done;
    logic [1:0] addr_out;
    logic [7:0] dout, din, last_count;
    logic       err_in = 1'b0, ec_in = 1'b0;
    logic [7:0] count_in = 8'd0;
    logic [2:0] status;

    int tests = 0;
    int fails = 0;

    logic [7:0] mem [4];
    bit         corrupt_ulr = 1'b0;

    int         n_wr = 0, n_rd = 0, n_oe = 0, n_start = 0, n_ncs_low = 0, n_ncs_fall = 0, n_bad = 0;
    logic [7:0] wr_log = 8'd0;
    logic       ncs_prev = 1'b1;

    up_down_counter255_host #(.TIMEOUT_CYC(16'd20), .VERIFY_EN(1)) dut (
        .clk_in(clk_in), .reset_in(reset_in), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .plr_in(plr_in), .ulr_in(ulr_in), .llr_in(llr_in), .ccr_in(ccr_in),
        .ncs_out(ncs_out), .nwr_out(nwr_out), .nrd_out(nrd_out), .addr_out(addr_out),
        .dout(dout), .dout_oe(dout_oe), .din(din), .start_out(start_out),
        .err_in(err_in), .ec_in(ec_in), .count_in(count_in),
        .done(done), .status(status), .last_count(last_count)
    );

    always #5 clk_in = ~clk_in;

    assign din = (corrupt_ulr && addr_out == 2'd1) ? 8'hFF : mem[addr_out];

    // Bus slave and protocol monitor; counters are free-running, tests use deltas.
    always @(posedge clk_in) begin
        if (!ncs_out && !nwr_out) mem[addr_out] <= dout;
        if (!nwr_out) begin
            n_wr   <= n_wr + 1;
            wr_log <= {addr_out, wr_log[7:2]};
        end
        if (!nrd_out) n_rd <= n_rd + 1;
        if (dout_oe) n_oe <= n_oe + 1;
        if (start_out) n_start <= n_start + 1;
        if (!ncs_out) n_ncs_low <= n_ncs_low + 1;
        if (ncs_prev && !ncs_out) n_ncs_fall <= n_ncs_fall + 1;
        if ((!nwr_out && !nrd_out) || (!nrd_out && dout_oe)) n_bad <= n_bad + 1;
        ncs_prev <= ncs_out;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic issue_cmd(input logic [7:0] p, input logic [7:0] u, input logic [7:0] l, input logic [7:0] c);
        @(negedge clk_in);
        plr_in = p; ulr_in = u; llr_in = l; ccr_in = c; cmd_valid = 1'b1;
        @(negedge clk_in);
        cmd_valid = 1'b0;
        plr_in = 8'hA5; ulr_in = 8'h5A; llr_in = 8'hC3; ccr_in = 8'h3C;
    endtask

    task automatic wait_start(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk_in);
            if (start_out) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_done(input int max, output int cyc, output bit ok);
        ok = 1'b0; cyc = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk_in);
            if (done) begin ok = 1'b1; cyc = i + 1; break; end
        end
    endtask

    task automatic test_reset();
        reset_in = 1'b1; cmd_valid = 1'b1;
        @(negedge clk_in);
        tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL reset_cmd_ready: got %b expected 0", cmd_ready); end
        @(negedge clk_in);
        tests++;
        if ({ncs_out, nwr_out, nrd_out, addr_out, dout, dout_oe, start_out, done, status, last_count} !==
            {1'b1, 1'b1, 1'b1, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0}) begin
            fails++;
            $display("FAIL reset_outputs: got ncs=%b nwr=%b nrd=%b addr=%0d dout=%0d oe=%b start=%b done=%b status=%0d last=%0d expected 1 1 1 0 0 0 0 0 0 0",
                     ncs_out, nwr_out, nrd_out, addr_out, dout, dout_oe, start_out, done, status, last_count);
        end
        reset_in = 1'b0; cmd_valid = 1'b0;
        @(negedge clk_in);
        tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL idle_cmd_ready: got %b expected 1", cmd_ready); end
    endtask

    task automatic test_nominal();
        int b_wr = n_wr, b_rd = n_rd, b_oe = n_oe, b_st = n_start, b_low = n_ncs_low, b_fall = n_ncs_fall, b_bad = n_bad;
        int cyc; bit ok;
        issue_cmd(8'd5, 8'd9, 8'd3, 8'd2);
        cmd_valid = 1'b1;
        tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL busy_cmd_ready: got %b expected 0", cmd_ready); end
        wait_start(60, ok);
        cmd_valid = 1'b0;
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL nom_start_seen: got %b expected 1", ok); end
        tests++; if (n_wr - b_wr != 4) begin fails++; $display("FAIL nom_write_strobes: got %0d expected 4", n_wr - b_wr); end
        tests++; if (n_oe - b_oe != 12) begin fails++; $display("FAIL nom_drive_cycles: got %0d expected 12", n_oe - b_oe); end
        tests++; if (n_rd - b_rd != 8) begin fails++; $display("FAIL nom_read_low_cycles: got %0d expected 8", n_rd - b_rd); end
        tests++; if (wr_log !== 8'hE4) begin fails++; $display("FAIL nom_write_order: got %h expected e4", wr_log); end
        tests++; if ({mem[3], mem[2], mem[1], mem[0]} !== 32'h02030905) begin
            fails++; $display("FAIL nom_reg_contents: got %h expected 02030905", {mem[3], mem[2], mem[1], mem[0]}); end
        repeat (2) @(negedge clk_in);
        ec_in = 1'b1; count_in = 8'd5;
        wait_done(10, cyc, ok);
        ec_in = 1'b0;
        tests++; if (ok !== 1'b1 || cyc != 1) begin fails++; $display("FAIL nom_done: got ok=%b cyc=%0d expected ok=1 cyc=1", ok, cyc); end
        tests++; if (status !== 3'd0) begin fails++; $display("FAIL nom_status: got %0d expected 0", status); end
        tests++; if (last_count !== 8'd5) begin fails++; $display("FAIL nom_last_count: got %0d expected 5", last_count); end
        tests++; if (ncs_out !== 1'b1) begin fails++; $display("FAIL nom_ncs_finish: got %b expected 1", ncs_out); end
        tests++; if (n_ncs_low - b_low != 27 || n_ncs_fall - b_fall != 1) begin
            fails++; $display("FAIL nom_ncs_continuous: got low=%0d falls=%0d expected low=27 falls=1", n_ncs_low - b_low, n_ncs_fall - b_fall); end
        tests++; if (n_start - b_st != 1) begin fails++; $display("FAIL nom_start_count: got %0d expected 1", n_start - b_st); end
        tests++; if (n_bad - b_bad != 0) begin fails++; $display("FAIL nom_strobe_overlap: got %0d expected 0", n_bad - b_bad); end
        @(negedge clk_in);
        tests++; if (done !== 1'b0 || status !== 3'd0) begin fails++; $display("FAIL nom_done_width: got done=%b status=%0d expected 0 0", done, status); end
    endtask

    task automatic test_param_error();
        int b_wr = n_wr, b_low = n_ncs_low;
        int cyc; bit ok;
        issue_cmd(8'd10, 8'd9, 8'd3, 8'd0);
        wait_done(5, cyc, ok);
        tests++; if (ok !== 1'b1 || cyc != 1) begin fails++; $display("FAIL perr_done: got ok=%b cyc=%0d expected ok=1 cyc=1", ok, cyc); end
        tests++; if (status !== 3'd2) begin fails++; $display("FAIL perr_status_hi: got %0d expected 2", status); end
        tests++; if (n_ncs_low - b_low != 0 || n_wr - b_wr != 0) begin
            fails++; $display("FAIL perr_no_bus: got ncs_low=%0d writes=%0d expected 0 0", n_ncs_low - b_low, n_wr - b_wr); end
        @(negedge clk_in);
        tests++; if (status !== 3'd2) begin fails++; $display("FAIL perr_status_hold: got %0d expected 2", status); end
        issue_cmd(8'd3, 8'd9, 8'd4, 8'd0);
        wait_done(5, cyc, ok);
        tests++; if (ok !== 1'b1 || status !== 3'd2) begin fails++; $display("FAIL perr_llr_status: got ok=%b status=%0d expected 1 2", ok, status); end
    endtask

    task automatic test_verify_fail();
        int b_wr = n_wr, b_rd = n_rd, b_st = n_start;
        int cyc; bit ok;
        corrupt_ulr = 1'b1;
        issue_cmd(8'd5, 8'd9, 8'd3, 8'd2);
        wait_done(60, cyc, ok);
        corrupt_ulr = 1'b0;
        tests++; if (ok !== 1'b1 || status !== 3'd3) begin fails++; $display("FAIL vfail_status: got ok=%b status=%0d expected 1 3", ok, status); end
        tests++; if (n_start - b_st != 0) begin fails++; $display("FAIL vfail_no_start: got %0d expected 0", n_start - b_st); end
        tests++; if (n_wr - b_wr != 4 || n_rd - b_rd != 4) begin
            fails++; $display("FAIL vfail_bus: got writes=%0d read_low=%0d expected 4 4", n_wr - b_wr, n_rd - b_rd); end
    endtask

    task automatic test_timeout();
        bit ok;
        issue_cmd(8'd5, 8'd9, 8'd3, 8'd2);
        wait_start(60, ok);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL tmo_start_seen: got %b expected 1", ok); end
        repeat (20) @(negedge clk_in);
        tests++; if ({status, done, ncs_out} !== {3'd0, 1'b0, 1'b0}) begin
            fails++; $display("FAIL tmo_early: got status=%0d done=%b ncs=%b expected 0 0 0", status, done, ncs_out); end
        @(negedge clk_in);
        tests++; if ({status, done, ncs_out} !== {3'd5, 1'b1, 1'b1}) begin
            fails++; $display("FAIL tmo_expire: got status=%0d done=%b ncs=%b expected 5 1 1", status, done, ncs_out); end
    endtask

    task automatic test_run_err();
        int cyc; bit ok;
        issue_cmd(8'd5, 8'd9, 8'd3, 8'd2);
        wait_start(60, ok);
        @(negedge clk_in);
        err_in = 1'b1; count_in = 8'h77;
        wait_done(10, cyc, ok);
        err_in = 1'b0;
        tests++; if (ok !== 1'b1 || status !== 3'd4) begin fails++; $display("FAIL rerr_status: got ok=%b status=%0d expected 1 4", ok, status); end
        tests++; if (last_count !== 8'd5) begin fails++; $display("FAIL rerr_last_count: got %0d expected 5", last_count); end
    endtask

    task automatic test_reset_mid();
        int b_wr;
        int cyc; bit ok;
        ok = 1'b0;
        issue_cmd(8'd5, 8'd9, 8'd3, 8'd2);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_in);
            if (!nwr_out && addr_out == 2'd3) begin ok = 1'b1; break; end
        end
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL rmid_ccr_strobe_seen: got %b expected 1", ok); end
        reset_in = 1'b1;
        @(negedge clk_in);
        tests++; if (nwr_out !== 1'b1) begin fails++; $display("FAIL rmid_nwr_release: got %b expected 1", nwr_out); end
        tests++;
        if ({ncs_out, nrd_out, addr_out, dout, dout_oe, start_out, done, status, last_count, cmd_ready} !==
            {1'b1, 1'b1, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0}) begin
            fails++;
            $display("FAIL rmid_outputs: got ncs=%b nrd=%b addr=%0d dout=%0d oe=%b start=%b done=%b status=%0d last=%0d rdy=%b expected 1 1 0 0 0 0 0 0 0 0",
                     ncs_out, nrd_out, addr_out, dout, dout_oe, start_out, done, status, last_count, cmd_ready);
        end
        reset_in = 1'b0;
        b_wr = n_wr;
        repeat (2) @(negedge clk_in);
        tests++; if (n_wr - b_wr != 0 || cmd_ready !== 1'b1) begin
            fails++; $display("FAIL rmid_quiet: got writes=%0d rdy=%b expected 0 1", n_wr - b_wr, cmd_ready); end
        issue_cmd(8'd4, 8'd8, 8'd2, 8'd1);
        wait_start(60, ok);
        @(negedge clk_in);
        ec_in = 1'b1; count_in = 8'h42;
        wait_done(10, cyc, ok);
        ec_in = 1'b0;
        tests++; if (ok !== 1'b1 || status !== 3'd0 || last_count !== 8'h42) begin
            fails++; $display("FAIL rmid_rerun: got ok=%b status=%0d last=%h expected 1 0 42", ok, status, last_count); end
        tests++; if ({mem[3], mem[2], mem[1], mem[0]} !== 32'h01020804) begin
            fails++; $display("FAIL rmid_reg_contents: got %h expected 01020804", {mem[3], mem[2], mem[1], mem[0]}); end
    endtask

    task automatic test_back_to_back();
        int cyc; bit ok;
        issue_cmd(8'd7, 8'd7, 8'd7, 8'd0);
        wait_start(60, ok);
        ec_in = 1'b1; err_in = 1'b1; count_in = 8'd7;
        wait_done(5, cyc, ok);
        ec_in = 1'b0; err_in = 1'b0;
        tests++; if (ok !== 1'b1 || cyc != 2) begin fails++; $display("FAIL b2b_done: got ok=%b cyc=%0d expected 1 2", ok, cyc); end
        tests++; if (status !== 3'd0 || last_count !== 8'd7) begin
            fails++; $display("FAIL b2b_ec_priority: got status=%0d last=%0d expected 0 7", status, last_count); end
        tests++; if ({mem[3], mem[2], mem[1], mem[0]} !== 32'h00070707) begin
            fails++; $display("FAIL b2b_reg_contents: got %h expected 00070707", {mem[3], mem[2], mem[1], mem[0]}); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_param_error();
        test_verify_fail();
        test_timeout();
        test_run_err();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
